// File: rtl/motor_rst_pkg.sv
// ==== motor_rst_pkg : shared types/helpers for the motor reset sequencer ====
// ==== Rev 1.0                                                            ====
`default_nettype none

package motor_rst_pkg;

   localparam int DEF_NUM_MOTORS = 8;
   localparam int DEF_CNT_W      = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } fsm_state_e;

   // Isolates the lowest set bit; callers size-cast the result to their width.
   function automatic logic [31:0] lowest_one_hot(input logic [31:0] v);
      return v & (~v + 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/motor_rst_hold_timer.sv
// ==== motor_rst_hold_timer : per-motor minimum-assert hold counter ====
// ==== Rev 1.0                                                      ====
`default_nettype none

module motor_rst_hold_timer #(
   parameter int HOLD_CYCLES = 1000,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req_q,
   input  logic asserted,
   output logic eligible
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= CNT_W'(HOLD_CYCLES);
      end else if (!req_q) begin
         cnt <= CNT_W'(HOLD_CYCLES);
      end else if (asserted && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign eligible = asserted & req_q & (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/motor_reset_sequencer.sv
// ==== motor_reset_sequencer : staggered per-motor reset release        ====
// ==== Optional: MOTOR_RST_FAULT_EN adds fault_n / fault_status. Rev 1.0 ====
`default_nettype none

module motor_reset_sequencer
   import motor_rst_pkg::*;
#(
   parameter int NUM_MOTORS     = DEF_NUM_MOTORS,
   parameter int HOLD_CYCLES    = 1000,
   parameter int STAGGER_CYCLES = 500,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_MOTORS-1:0] req_reset_n,
   output logic [NUM_MOTORS-1:0] motor_rst_n,
   output logic                  busy,
`ifdef MOTOR_RST_FAULT_EN
   input  logic [NUM_MOTORS-1:0] fault_n,
   output logic [NUM_MOTORS-1:0] fault_status,
`endif
   output logic [NUM_MOTORS-1:0] released
);

   localparam logic [0:0] S_IDLE = ST_IDLE;
   localparam logic [0:0] S_GAP  = ST_GAP;

   logic [NUM_MOTORS-1:0] req_q;
   logic [NUM_MOTORS-1:0] req_eff;
   logic [NUM_MOTORS-1:0] req_eff_d;
   logic [NUM_MOTORS-1:0] eligible;
   logic [NUM_MOTORS-1:0] pick;
   logic [NUM_MOTORS-1:0] rst_d;
   logic [0:0]            state;
   logic [0:0]            state_d;
   logic [CNT_W-1:0]      gap;
   logic [CNT_W-1:0]      gap_d;
   logic                  release_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) req_q <= '0;
      else          req_q <= req_reset_n;
   end

`ifdef MOTOR_RST_FAULT_EN
   logic [NUM_MOTORS-1:0] fault_meta;
   logic [NUM_MOTORS-1:0] fault_sync;
   logic [NUM_MOTORS-1:0] fault_latched;
   logic [NUM_MOTORS-1:0] fault_lat_d;

   // Sticky until software holds the motor in reset while the fault is gone.
   assign fault_lat_d = ~fault_sync | (fault_latched & ~(~req_q & fault_sync));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_meta    <= '1;
         fault_sync    <= '1;
         fault_latched <= '0;
      end else begin
         fault_meta    <= fault_n;
         fault_sync    <= fault_meta;
         fault_latched <= fault_lat_d;
      end
   end

   assign req_eff      = req_q & ~fault_latched;
   assign req_eff_d    = req_reset_n & ~fault_lat_d;
   assign fault_status = fault_latched;
`else
   assign req_eff   = req_q;
   assign req_eff_d = req_reset_n;
`endif

   for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_hold
      motor_rst_hold_timer #(
         .HOLD_CYCLES (HOLD_CYCLES),
         .CNT_W       (CNT_W)
      ) u_hold (
         .clk      (clk),
         .reset_n  (reset_n),
         .req_q    (req_eff[i]),
         .asserted (~motor_rst_n[i]),
         .eligible (eligible[i])
      );
   end

   assign pick = NUM_MOTORS'(lowest_one_hot(32'(eligible)));

   always_comb begin
      state_d    = state;
      gap_d      = gap;
      release_en = 1'b0;
      if (state == S_IDLE) begin
         if (|eligible) begin
            release_en = 1'b1;
            gap_d      = CNT_W'(STAGGER_CYCLES);
            state_d    = S_GAP;
         end
      end else begin
         if (gap != '0) begin
            gap_d = gap - 1'b1;
         end else if (|eligible) begin
            release_en = 1'b1;
            gap_d      = CNT_W'(STAGGER_CYCLES);
         end else begin
            state_d = S_IDLE;
         end
      end
      // Assertion overrides any release in the same cycle.
      rst_d = (motor_rst_n | (release_en ? pick : '0)) & req_eff;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         gap         <= '0;
         motor_rst_n <= '0;
         released    <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         gap         <= gap_d;
         motor_rst_n <= rst_d;
         released    <= rst_d;
         busy        <= (state_d == S_GAP) | (|(~rst_d & req_eff_d));
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_motor_reset_sequencer.sv
// ==== tb_motor_reset_sequencer : directed self-checking bench (N=8, HOLD=4, STAGGER=3) ====
// ==== Rev 1.0                                                                         ====
`default_nettype none

module tb_motor_reset_sequencer;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] req_reset_n;
   logic [N-1:0] motor_rst_n;
   logic         busy;
   logic [N-1:0] released;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   motor_reset_sequencer #(
      .NUM_MOTORS     (N),
      .HOLD_CYCLES    (4),
      .STAGGER_CYCLES (3),
      .CNT_W          (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_reset_n (req_reset_n),
      .motor_rst_n (motor_rst_n),
      .busy        (busy),
      .released    (released)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) tick();
   endtask

   initial begin
      int b;
      logic [N-1:0] e;

      reset_n     = 1'b0;
      req_reset_n = '0;
      #23;
      check("rst_motor", 32'(motor_rst_n), 32'h00);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_released", 32'(released), 32'h00);
      tick();
      reset_n = 1'b1;

      // Held requests never release anything.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_motor", 32'(motor_rst_n), 32'h00);
         check("idle_busy", 32'(busy), 32'h0);
      end

      // Full staggered release: bit k rises at b+6+4k.
      b = cyc;
      req_reset_n = 8'hFF;
      run_to(b + 5);
      check("seq_hold", 32'(motor_rst_n), 32'h00);
      check("seq_busy", 32'(busy), 32'h1);
      for (int k = 0; k < N; k++) begin
         if (k > 0) begin
            run_to(b + 6 + 4*k - 1);
            e = N'((1 << k) - 1);
            check("seq_before", 32'(motor_rst_n), 32'(e));
         end
         run_to(b + 6 + 4*k);
         e = N'((1 << (k + 1)) - 1);
         check("seq_rise", 32'(motor_rst_n), 32'(e));
      end
      run_to(b + 37);
      check("seq_gap_busy", 32'(busy), 32'h1);
      run_to(b + 38);
      check("seq_done_busy", 32'(busy), 32'h0);
      check("seq_released", 32'(released), 32'hFF);

      // Single-cycle pulse on bit 3.
      b = cyc;
      req_reset_n = 8'hF7;
      tick();
      check("p3_lat1", 32'(motor_rst_n), 32'hFF);
      req_reset_n = 8'hFF;
      run_to(b + 2);
      check("p3_fall", 32'(motor_rst_n), 32'hF7);
      check("p3_released", 32'(released), 32'hF7);
      run_to(b + 3);
      check("p3_busy", 32'(busy), 32'h1);
      run_to(b + 6);
      check("p3_hold", 32'(motor_rst_n), 32'hF7);
      run_to(b + 7);
      check("p3_rise", 32'(motor_rst_n), 32'hFF);
      run_to(b + 12);
      check("p3_idle", 32'(busy), 32'h0);

      // Bits 1 and 6 pulsed; bit 5 drops in the middle of the gap.
      b = cyc;
      req_reset_n = 8'hBD;
      tick();
      req_reset_n = 8'hFF;
      run_to(b + 2);
      check("gap_fall", 32'(motor_rst_n), 32'hBD);
      run_to(b + 7);
      check("gap_rise1", 32'(motor_rst_n), 32'hBF);
      run_to(b + 8);
      req_reset_n = 8'hDF;
      tick();
      req_reset_n = 8'hFF;
      run_to(b + 10);
      check("gap_fall5", 32'(motor_rst_n), 32'h9F);
      check("gap_busy", 32'(busy), 32'h1);
      run_to(b + 11);
      check("gap_rise6", 32'(motor_rst_n), 32'hDF);
      run_to(b + 14);
      check("gap_hold5", 32'(motor_rst_n), 32'hDF);
      run_to(b + 15);
      check("gap_rise5", 32'(motor_rst_n), 32'hFF);
      run_to(b + 18);
      check("gap_busy_end", 32'(busy), 32'h1);
      run_to(b + 19);
      check("gap_idle", 32'(busy), 32'h0);

      // Bit 2 toggles faster than the hold time and must stay low.
      b = cyc;
      req_reset_n = 8'hFB;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i >= 2) check("tog_low", 32'(motor_rst_n), 32'hFB);
         req_reset_n = (((i / 3) % 2) == 0) ? 8'hFB : 8'hFF;
      end
      req_reset_n = 8'hFF;
      repeat (20) tick();
      check("tog_recover", 32'(motor_rst_n), 32'hFF);

      // Async reset mid-sequence, then restart from bit 0.
      b = cyc;
      req_reset_n = 8'h00;
      run_to(b + 3);
      check("ar_all_low", 32'(motor_rst_n), 32'h00);
      run_to(b + 8);
      req_reset_n = 8'hFF;
      b = cyc;
      run_to(b + 15);
      check("ar_partial", 32'(motor_rst_n), 32'h07);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_motor", 32'(motor_rst_n), 32'h00);
      check("ar_busy", 32'(busy), 32'h0);
      check("ar_released", 32'(released), 32'h00);
      tick();
      tick();
      check("ar_held", 32'(motor_rst_n), 32'h00);
      reset_n = 1'b1;
      b = cyc;
      run_to(b + 5);
      check("ar_rehold", 32'(motor_rst_n), 32'h00);
      check("ar_rebusy", 32'(busy), 32'h1);
      run_to(b + 6);
      check("ar_bit0", 32'(motor_rst_n), 32'h01);
      run_to(b + 10);
      check("ar_bit1", 32'(motor_rst_n), 32'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
